// File: rtl/vga_capture.sv
// Video timing capture: locks onto hsync/vsync framing, tags pixels with coordinates and measures line/frame size.
// Optional frame checksum enabled by defining VGA_CAPTURE_CHECKSUM_EN.
module vga_capture #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pixel_valid,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] meas_width,
  output logic [15:0] meas_height,
  output logic [15:0] frame_checksum
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

  logic [1:0]  state_reg, state_next;
  logic        vsync_prev_reg;
  logic [15:0] x_reg, y_reg, x_next, y_next, cur_x, cur_y;
  logic [15:0] line_cnt_reg, line_cnt_inc;
  logic [15:0] hs_cnt_reg, hs_cnt_base, hs_cnt_next;
  logic        boundary, violation, valid_next, first_pixel, last_pixel;
  logic [11:0] rgb;

  always_comb begin
    rgb      = {red, green, blue};
    boundary = vsync_prev_reg && !vsync;
    // The boundary sample is pixel (0,0) regardless of where the counters had got to.
    cur_x    = boundary ? 16'd0 : x_reg;
    cur_y    = boundary ? 16'd0 : y_reg;

    first_pixel = (cur_x == 16'd0) && (cur_y == 16'd0);
    last_pixel  = (cur_x == X_LAST) && (cur_y == Y_LAST);

    if (cur_x == X_LAST) begin
      x_next = 16'd0;
      y_next = (cur_y == Y_LAST) ? 16'd0 : cur_y + 16'd1;
    end else begin
      x_next = cur_x + 16'd1;
      y_next = cur_y;
    end

    violation = (state_reg != SEARCH) &&
                ((hsync != (cur_x == X_LAST)) || (vsync != (cur_y == Y_LAST)));

    state_next = state_reg;
    case (state_reg)
      SEARCH: if (boundary) state_next = CHECK;
      CHECK: begin
        if (violation)     state_next = SEARCH;
        else if (boundary) state_next = LOCKED;
      end
      LOCKED: if (violation) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
    valid_next = (state_next == LOCKED);

    line_cnt_inc = (line_cnt_reg == 16'hFFFF) ? 16'hFFFF : line_cnt_reg + 16'd1;
    hs_cnt_base  = boundary ? 16'd0 : hs_cnt_reg;
    hs_cnt_next  = (hs_cnt_base == 16'hFFFF) ? 16'hFFFF : hs_cnt_base + {15'd0, hsync};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= SEARCH;
      vsync_prev_reg <= 1'b0;
      x_reg          <= 16'd0;
      y_reg          <= 16'd0;
      line_cnt_reg   <= 16'd0;
      hs_cnt_reg     <= 16'd0;
      pixel_valid    <= 1'b0;
      pixel_x        <= 16'd0;
      pixel_y        <= 16'd0;
      pixel_rgb      <= 12'd0;
      frame_start    <= 1'b0;
      locked         <= 1'b0;
      sync_err       <= 1'b0;
      meas_width     <= 16'd0;
      meas_height    <= 16'd0;
    end else begin
      state_reg      <= state_next;
      vsync_prev_reg <= vsync;
      x_reg          <= x_next;
      y_reg          <= y_next;
      pixel_valid    <= valid_next;
      locked         <= valid_next;
      pixel_x        <= cur_x;
      pixel_y        <= cur_y;
      pixel_rgb      <= rgb;
      frame_start    <= valid_next && first_pixel;
      sync_err       <= violation;
      // Line length counts clocks since the previous hsync, inclusive of the hsync clock.
      if (hsync) begin
        meas_width   <= line_cnt_inc;
        line_cnt_reg <= 16'd0;
      end else begin
        line_cnt_reg <= line_cnt_inc;
      end
      if (boundary) meas_height <= hs_cnt_reg;
      hs_cnt_reg <= hs_cnt_next;
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] acc_reg, acc_sum;

  assign acc_sum = (first_pixel ? 16'd0 : acc_reg) + {4'd0, rgb};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= 16'd0;
      frame_checksum <= 16'd0;
    end else if (valid_next) begin
      acc_reg <= acc_sum;
      if (last_pixel) frame_checksum <= acc_sum;
    end
  end
`else
  assign frame_checksum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: short vector table, then generated frames checked against an index-based reference model.
module tb_vga_capture;

  localparam int W = 16;
  localparam int H = 12;

  logic        clk, reset, hsync, vsync;
  logic [3:0]  red, green, blue;
  logic        pixel_valid, frame_start, locked, sync_err;
  logic [15:0] pixel_x, pixel_y, meas_width, meas_height, frame_checksum;
  logic [11:0] pixel_rgb;

  vga_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err), .meas_width(meas_width), .meas_height(meas_height),
    .frame_checksum(frame_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] rgb;
    logic        fs;
    logic        locked;
    logic        serr;
    logic [15:0] mw;
    logic [15:0] mh;
    logic [15:0] cs;
  } outs_t;

  typedef struct {
    logic        r, h, v;
    logic        lock, serr;
    logic [15:0] mw, mh;
  } vec_t;

  outs_t dut_o, exp_o;
  assign dut_o = {pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_start, locked,
                  sync_err, meas_width, meas_height, frame_checksum};

  int pass_count = 0;
  int total_count = 0;

  // Reference model state: everything is derived from sample indices.
  int n = 0;
  int bidx = 0;
  int last_h = -1;
  int hcnt = 0;
  int mode = 0;
  int unsigned sum = 0;
  logic prev_v = 1'b0;

  int serr_count = 0;
  int rise_sample = -1;
  logic locked_prev = 1'b0;
  logic pix_check = 1'b0;
  logic seen_a = 1'b0;
  logic seen_b = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total_count++;
    if (got === want) pass_count++;
    else $display("FAIL %s at sample %0d: got %h, expected %h", name, n - 1, got, want);
  endtask

  task automatic model(input logic r, input logic h, input logic v, input logic [11:0] c);
    int k, x, y;
    logic bnd, viol;
    if (r) begin
      mode = 0; prev_v = 1'b0; bidx = n + 1; last_h = n; hcnt = 0; sum = 0;
      exp_o = '0;
      n++;
      return;
    end
    bnd = prev_v && !v;
    if (bnd) bidx = n;
    k = n - bidx;
    x = k % W;
    y = (k / W) % H;
    viol = (mode != 0) && ((h != (x == W - 1)) || (v != (y == H - 1)));
    if (mode == 0 && bnd) mode = 1;
    else if (mode == 1 && viol) mode = 0;
    else if (mode == 1 && bnd) mode = 2;
    else if (mode == 2 && viol) mode = 0;
    exp_o.valid  = (mode == 2);
    exp_o.locked = (mode == 2);
    exp_o.x      = 16'(x);
    exp_o.y      = 16'(y);
    exp_o.rgb    = c;
    exp_o.fs     = (mode == 2) && x == 0 && y == 0;
    exp_o.serr   = viol;
    if (h) begin
      exp_o.mw = 16'((n - last_h > 65535) ? 65535 : n - last_h);
      last_h = n;
    end
    if (bnd) begin
      exp_o.mh = 16'((hcnt > 65535) ? 65535 : hcnt);
      hcnt = 0;
    end
    if (h) hcnt++;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    if (mode == 2) begin
      sum = (x == 0 && y == 0) ? 32'(c) : sum + 32'(c);
      if (x == W - 1 && y == H - 1) exp_o.cs = 16'(sum);
    end
`endif
    prev_v = v;
    n++;
  endtask

  task automatic step(input logic r, input logic h, input logic v, input logic [11:0] c);
    reset = r; hsync = h; vsync = v; {red, green, blue} = c;
    model(r, h, v, c);
    @(negedge clk);
    check("outputs", 128'(dut_o), 128'(exp_o));
    if (sync_err) serr_count++;
    if (locked && !locked_prev) rise_sample = n - 1;
    locked_prev = locked;
    if (pix_check && exp_o.valid && exp_o.x == 16'd10 && exp_o.y == 16'd5 && !seen_a) begin
      seen_a = 1'b1;
      check("pixel_10_5_rgb", 128'(pixel_rgb), 128'(12'hF00));
    end
    if (pix_check && exp_o.valid && exp_o.x == 16'd3 && exp_o.y == 16'd4 && !seen_b) begin
      seen_b = 1'b1;
      check("pixel_3_4_rgb", 128'(pixel_rgb), 128'(12'h00F));
    end
  endtask

  // cmode: 0 grid pattern, 1 random colour, 2 constant 0x001. Glitch/reset apply to the first frame.
  task automatic gen(input int frames, input int llen, input int glitch_y, input int rst_y,
                     input int cmode, input logic noise);
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < llen; x++) begin
          logic h, v, r;
          logic [11:0] c;
          h = (x == llen - 1);
          v = (y == H - 1);
          if (f == 0 && y == glitch_y && x == llen - 1) h = 1'b0;
          if (f == 0 && y == glitch_y + 1 && x == 0) h = 1'b1;
          r = (f == 0 && y == rst_y && x == 0);
          case (cmode)
            0: c = (x % 10 == 0 || y % 10 == 0) ? 12'hF00 : 12'h00F;
            1: c = 12'($urandom_range(0, 4095));
            default: c = 12'h001;
          endcase
          if (noise && $urandom_range(0, 299) == 0) h = ~h;
          if (noise && $urandom_range(0, 299) == 0) v = ~v;
          step(r, h, v, c);
        end
  endtask

  vec_t tbl[9];
  int s0, s_b;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2};

    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; red = 4'd0; green = 4'd0; blue = 4'd0;
    @(negedge clk);
    check("reset_outputs", 128'(dut_o), 128'd0);

    // Short hand-built sequence: line length, height count, and a CHECK violation.
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].r; hsync = tbl[i].h; vsync = tbl[i].v; {red, green, blue} = 12'h5A3;
      @(negedge clk);
      check($sformatf("table_row%0d", i), 128'({locked, sync_err, meas_width, meas_height}),
            128'({tbl[i].lock, tbl[i].serr, tbl[i].mw, tbl[i].mh}));
    end

    // Ideal generator from reset: lock two boundaries in, grid colours.
    step(1'b1, 1'b0, 1'b0, 12'h000);
    s0 = n;
    rise_sample = -1;
    pix_check = 1'b1;
    gen(4, W, -1, -1, 0, 1'b0);
    pix_check = 1'b0;
    check("lock_rise_sample", 128'(rise_sample), 128'(s0 + 2 * W * H));
    check("meas_width_ideal", 128'(meas_width), 128'(W));
    check("meas_height_ideal", 128'(meas_height), 128'(H));
    check("seen_pixels", 128'({seen_a, seen_b}), 128'(2'b11));

    // Late hsync on one line while locked, then recovery.
    serr_count = 0;
    gen(3, W, 5, -1, 1, 1'b0);
    check("glitch_serr_pulses", 128'(serr_count), 128'd1);
    check("glitch_relocked", 128'(locked), 128'd1);

    // Lines one clock short: never locks.
    serr_count = 0;
    gen(3, W - 1, -1, -1, 1, 1'b0);
    check("short_serr_pulses", 128'(serr_count), 128'd3);
    check("short_not_locked", 128'(locked), 128'd0);
    check("short_meas_width", 128'(meas_width), 128'(W - 1));

    // Reset mid-frame while locked, then relock one frame after first boundary.
    gen(2, W, -1, -1, 1, 1'b0);
    check("pre_reset_locked", 128'(locked), 128'd1);
    gen(1, W, -1, 6, 1, 1'b0);
    s_b = n;
    rise_sample = -1;
    gen(3, W, -1, -1, 1, 1'b0);
    check("post_reset_rise", 128'(rise_sample), 128'(s_b + W * H));

    // Random colours with sparse sync bit flips.
    gen(6, W, -1, -1, 1, 1'b1);

    // Constant colour for the checksum.
    step(1'b1, 1'b0, 1'b0, 12'h000);
    gen(4, W, -1, -1, 2, 1'b0);
`ifdef VGA_CAPTURE_CHECKSUM_EN
    check("frame_checksum", 128'(frame_checksum), 128'(16'(W * H)));
`else
    check("frame_checksum", 128'(frame_checksum), 128'd0);
`endif

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
